// File: rtl/decr_pkg.sv
// Shared constants and the stage-1 payload type for the pipelined borrow
// decrementer. The payload struct is sized from the default operand width.
package decr_pkg;

  localparam int DECR_DEFAULT_WIDTH = 8;
  localparam int DECR_SLICE_WIDTH   = 2;
  localparam int DECR_HALF_WIDTH    = DECR_DEFAULT_WIDTH / 2;

  // Everything the upper half needs to finish the subtraction one cycle later
  typedef struct packed {
    logic [DECR_HALF_WIDTH-1:0] lowDiff;
    logic                       midBorrow;
    logic [DECR_HALF_WIDTH-1:0] highA;
  } decr_stage1_t;

endpackage

// File: rtl/two_bit_borrow_lookahead_decrementer.sv
// Two-bit borrow-lookahead decrement slice. A borrow ripples through a bit
// only when every lower bit of the slice is zero, so both the difference and
// the slice borrow-out come straight from the zero-detect of the lower bits.
module two_bit_borrow_lookahead_decrementer (
  input  logic [1:0] a,
  input  logic       bin,
  output logic [1:0] diff,
  output logic       bout
);

  // Bit 0 flips on any borrow; bit 1 flips only when bit 0 is already zero
  always_comb begin
    diff[0] = a[0] ^ bin;
    diff[1] = a[1] ^ (bin & ~a[0]);
    bout    = bin & (a == 2'b00);
  end

endmodule

// File: rtl/pipelined_borrow_decrementer.sv
// Two-stage pipelined decrementer (in_a - in_bin) with valid/ready handshakes.
// Stage 1 resolves the lower half and the mid borrow; stage 2 finishes the
// upper half and holds the complete result for the consumer.
// Optional build macro DECR_SATURATE_EN: the wrap-around case (0 - 1) yields
// zero instead of all ones; the borrow-out is still raised.
module pipelined_borrow_decrementer
  import decr_pkg::*;
#(
  parameter int WIDTH = DECR_DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_bout
);

  localparam int HALF        = WIDTH / 2;
  localparam int HALF_SLICES = HALF / DECR_SLICE_WIDTH;

  logic               s1Valid_q, s1Valid_d;
  decr_stage1_t       s1Data_q, s1Data_d;
  logic               s2Valid_q, s2Valid_d;
  logic [WIDTH-1:0]   s2Diff_q, s2Diff_d;
  logic               s2Bout_q, s2Bout_d;

  logic               s1Ready;
  logic               s2Ready;

  logic [HALF-1:0]        lowDiff;
  logic [HALF_SLICES:0]   lowBorrow;
  logic [HALF-1:0]        highDiff;
  logic [HALF_SLICES:0]   highBorrow;
  logic [WIDTH-1:0]       fullDiff;
  logic                   fullBout;

  assign lowBorrow[0]  = in_bin;
  assign highBorrow[0] = s1Data_q.midBorrow;

  // Lower-half slices work directly on the incoming operand
  for (genvar i = 0; i < HALF_SLICES; i++) begin : gLow
    two_bit_borrow_lookahead_decrementer uLowSlice (
      .a    (in_a[2*i+1:2*i]),
      .bin  (lowBorrow[i]),
      .diff (lowDiff[2*i+1:2*i]),
      .bout (lowBorrow[i+1])
    );
  end

  // Upper-half slices work on the operand bits parked in stage 1
  for (genvar i = 0; i < HALF_SLICES; i++) begin : gHigh
    two_bit_borrow_lookahead_decrementer uHighSlice (
      .a    (s1Data_q.highA[2*i+1:2*i]),
      .bin  (highBorrow[i]),
      .diff (highDiff[2*i+1:2*i]),
      .bout (highBorrow[i+1])
    );
  end

  // A stage can take new data when empty or when its contents leave this edge
  always_comb begin
    s2Ready  = !s2Valid_q || out_ready;
    s1Ready  = !s1Valid_q || s2Ready;
    in_ready = s1Ready;
    fullDiff = {highDiff, s1Data_q.lowDiff};
    fullBout = highBorrow[HALF_SLICES];
  end

  // Next-state for both stages; contents are held unless the stage is ready
  always_comb begin
    s1Valid_d = s1Valid_q;
    s1Data_d  = s1Data_q;
    s2Valid_d = s2Valid_q;
    s2Diff_d  = s2Diff_q;
    s2Bout_d  = s2Bout_q;
    if (s1Ready) begin
      s1Valid_d = in_valid;
      if (in_valid) begin
        s1Data_d.lowDiff   = lowDiff;
        s1Data_d.midBorrow = lowBorrow[HALF_SLICES];
        s1Data_d.highA     = in_a[WIDTH-1:HALF];
      end
    end
    if (s2Ready) begin
      s2Valid_d = s1Valid_q;
      if (s1Valid_q) begin
        s2Bout_d = fullBout;
`ifdef DECR_SATURATE_EN
        s2Diff_d = fullBout ? '0 : fullDiff;
`else
        s2Diff_d = fullDiff;
`endif
      end
    end
  end

  // Pipeline registers; reset drops every in-flight operand and clears outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid_q <= 1'b0;
      s1Data_q  <= '0;
      s2Valid_q <= 1'b0;
      s2Diff_q  <= '0;
      s2Bout_q  <= 1'b0;
    end else begin
      s1Valid_q <= s1Valid_d;
      s1Data_q  <= s1Data_d;
      s2Valid_q <= s2Valid_d;
      s2Diff_q  <= s2Diff_d;
      s2Bout_q  <= s2Bout_d;
    end
  end

  assign out_valid = s2Valid_q;
  assign out_diff  = s2Diff_q;
  assign out_bout  = s2Bout_q;

endmodule

// File: tb/tb_pipelined_borrow_decrementer.sv
// Testbench for pipelined_borrow_decrementer (WIDTH = 8). Honours
// DECR_SATURATE_EN the same way as the design build.
module tb_pipelined_borrow_decrementer;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic             in_bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_diff;
  logic             out_bout;

  int errorCount = 0;
  int checkCount = 0;

  logic [WIDTH:0]   modelQ[$];
  logic [WIDTH-1:0] seenDiff[$];
  logic             prevHeld = 1'b0;
  logic [WIDTH-1:0] prevDiff = '0;
  logic             prevBout = 1'b0;
  int               cycleCount = 0;
  logic             streamOn = 1'b0;
  int               streamCount = 0;
  int               streamFirst = 0;
  int               streamLast = 0;

  pipelined_borrow_decrementer #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_bin    (in_bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_bout  (out_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {bout, diff} from plain modular arithmetic
  function automatic logic [WIDTH:0] modelDecr(input logic [WIDTH-1:0] a, input logic bin);
    logic [WIDTH-1:0] d;
    logic             b;
    d = a - WIDTH'(bin);
    b = (a == '0) && bin;
`ifdef DECR_SATURATE_EN
    if (b) d = '0;
`endif
    return {b, d};
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Present one operand and wait (bounded) until the block takes it
  task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic bin);
    bit accepted = 0;
    int waited = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_bin   = bin;
    while (!accepted && waited < 50) begin
      @(negedge clk);
      if (in_ready) accepted = 1;
      @(posedge clk);
      #1;
      waited++;
    end
    in_valid = 1'b0;
    if (!accepted) checkOutput("acceptTimeout", 32'(0), 32'(1));
  endtask

  // Scoreboard: compare every presented result, check stalls hold, log accepts
  always @(negedge clk) begin
    if (!rst_n) begin
      modelQ.delete();
      prevHeld = 1'b0;
    end else begin
      cycleCount++;
      if (prevHeld) begin
        checkOutput("holdValid", 32'(out_valid), 32'(1));
        checkOutput("holdDiff", 32'(out_diff), 32'(prevDiff));
        checkOutput("holdBout", 32'(out_bout), 32'(prevBout));
      end
      if (out_valid) begin
        if (modelQ.size() == 0) begin
          checkOutput("unexpectedResult", 32'(out_valid), 32'(0));
        end else begin
          checkOutput("modelDiff", 32'(out_diff), 32'(modelQ[0][WIDTH-1:0]));
          checkOutput("modelBout", 32'(out_bout), 32'(modelQ[0][WIDTH]));
          if (out_ready) begin
            void'(modelQ.pop_front());
            seenDiff.push_back(out_diff);
            if (streamOn) begin
              if (streamCount == 0) streamFirst = cycleCount;
              streamLast = cycleCount;
              streamCount++;
            end
          end
        end
      end
      if (in_valid && in_ready) modelQ.push_back(modelDecr(in_a, in_bin));
      prevHeld = out_valid && !out_ready;
      prevDiff = out_diff;
      prevBout = out_bout;
    end
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_bin    = 1'b0;
    out_ready = 1'b1;

    // Reset state
    @(posedge clk);
    #1;
    checkOutput("rstOutValid", 32'(out_valid), 32'(0));
    checkOutput("rstOutDiff", 32'(out_diff), 32'(0));
    checkOutput("rstOutBout", 32'(out_bout), 32'(0));
    checkOutput("rstInReady", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("postRstInReady", 32'(in_ready), 32'(1));

    // 0x10 - 1 with latency check
    applyStimulus(8'h10, 1'b1);
    checkOutput("latencyEarly", 32'(out_valid), 32'(0));
    @(posedge clk);
    #1;
    checkOutput("latencyValid", 32'(out_valid), 32'(1));
    checkOutput("dec10Diff", 32'(out_diff), 32'(8'h0F));
    checkOutput("dec10Bout", 32'(out_bout), 32'(0));

    // Wrap-around
    applyStimulus(8'h00, 1'b1);
    @(posedge clk);
    #1;
    checkOutput("wrapValid", 32'(out_valid), 32'(1));
`ifdef DECR_SATURATE_EN
    checkOutput("wrapDiff", 32'(out_diff), 32'(8'h00));
`else
    checkOutput("wrapDiff", 32'(out_diff), 32'(8'hFF));
`endif
    checkOutput("wrapBout", 32'(out_bout), 32'(1));

    // Pass-through with no borrow
    applyStimulus(8'h5A, 1'b0);
    @(posedge clk);
    #1;
    checkOutput("passValid", 32'(out_valid), 32'(1));
    checkOutput("passDiff", 32'(out_diff), 32'(8'h5A));
    checkOutput("passBout", 32'(out_bout), 32'(0));
    repeat (3) @(posedge clk);
    #1;

    // Back-to-back operands against a stalled consumer
    seenDiff.delete();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bin    = 1'b1;
    in_a      = 8'h03;
    @(posedge clk);
    #1;
    in_a = 8'h02;
    @(posedge clk);
    #1;
    in_a = 8'h01;
    checkOutput("b2bInReadyDrop", 32'(in_ready), 32'(0));
    checkOutput("b2bStallValid", 32'(out_valid), 32'(1));
    checkOutput("b2bStallDiff", 32'(out_diff), 32'(8'h02));
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("b2bHoldDiff", 32'(out_diff), 32'(8'h02));
      checkOutput("b2bHoldInReady", 32'(in_ready), 32'(0));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("b2bCount", 32'(seenDiff.size()), 32'(3));
    if (seenDiff.size() == 3) begin
      checkOutput("b2bOrder0", 32'(seenDiff[0]), 32'(8'h02));
      checkOutput("b2bOrder1", 32'(seenDiff[1]), 32'(8'h01));
      checkOutput("b2bOrder2", 32'(seenDiff[2]), 32'(8'h00));
    end

    // Reset while both stages hold data
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bin    = 1'b1;
    in_a      = 8'h33;
    @(posedge clk);
    #1;
    in_a = 8'h44;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("fullOutValid", 32'(out_valid), 32'(1));
    checkOutput("fullInReady", 32'(in_ready), 32'(0));
    rst_n = 1'b0;
    #1;
    checkOutput("midRstOutValid", 32'(out_valid), 32'(0));
    checkOutput("midRstInReady", 32'(in_ready), 32'(1));
    checkOutput("midRstOutDiff", 32'(out_diff), 32'(0));
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput("noStaleResult", 32'(out_valid), 32'(0));
    end

    // Streaming random operands at full rate
    streamOn    = 1'b1;
    streamCount = 0;
    for (int i = 0; i < 256; i++) begin
      in_valid = 1'b1;
      in_a     = WIDTH'($urandom);
      in_bin   = 1'($urandom_range(0, 1));
      @(negedge clk);
      checkOutput("streamInReady", 32'(in_ready), 32'(1));
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 20 && streamCount < 256; i++) @(posedge clk);
    #1;
    streamOn = 1'b0;
    checkOutput("streamCount", 32'(streamCount), 32'(256));
    checkOutput("streamRate", 32'(streamLast - streamFirst), 32'(255));
    checkOutput("streamDrained", 32'(modelQ.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
